// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer (CTRL/PRESET/COUNT) with one-shot/auto-reload modes and a masked level irq; ports clk, reset, addr, we, byteen, wdata -> rdata, irq
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t state, state_nx;
  logic [3:0] ctrl, ctrl_nx;
  logic [31:0] preset, preset_nx, count, count_nx, mask;
  logic pend, pend_nx, sel, wr_ctrl, wr_pre;
  assign sel = addr[31:4] == BASE[31:4];
  assign wr_ctrl = we & sel & (addr[3:2] == 2'd0);
  assign wr_pre = we & sel & (addr[3:2] == 2'd1);
  assign mask = {{8{byteen[3]}}, {8{byteen[2]}}, {8{byteen[1]}}, {8{byteen[0]}}};
  assign rdata = !sel ? 32'd0 :
                 addr[3:2] == 2'd0 ? {28'd0, ctrl} :
                 addr[3:2] == 2'd1 ? preset :
                 addr[3:2] == 2'd2 ? count : 32'd0;
  always_comb begin
    state_nx = state;
    ctrl_nx = ctrl;
    count_nx = count;
    pend_nx = pend;
    case (state)
      IDLE: state_nx = ctrl[0] ? LOAD : IDLE;
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT:
        if (!ctrl[0]) state_nx = IDLE;
        else if (count > 32'd1) count_nx = count - 32'd1;
        else begin
          count_nx = 32'd0;
          pend_nx = 1'b1;
          state_nx = INT;
        end
      INT: begin
        state_nx = IDLE;
        if (ctrl[2:1] == 2'b01) pend_nx = 1'b0;
        else ctrl_nx[0] = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
    // a software write to CTRL/PRESET is an acknowledge and overrides the FSM's own update
    if (wr_ctrl | wr_pre) pend_nx = 1'b0;
    if (wr_ctrl & byteen[0]) ctrl_nx = wdata[3:0];
    preset_nx = wr_pre ? (preset & ~mask) | (wdata & mask) : preset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ctrl <= 4'd0;
      preset <= 32'd0;
      count <= 32'd0;
      pend <= 1'b0;
      irq <= 1'b0;
    end else begin
      state <= state_nx;
      ctrl <= ctrl_nx;
      preset <= preset_nx;
      count <= count_nx;
      pend <= pend_nx;
      // built from next-state values so irq rises on the same edge PEND does
      irq <= pend_nx & ctrl_nx[3];
    end
  end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed scenarios plus randomized traffic checked against a behavioural timer model
module tb_timer_counter;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_FIRE = 3;
  logic clk = 1'b0, reset = 1'b0, we = 1'b0, irq;
  logic [3:0] byteen = 4'h0;
  logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
  int checks = 0, failures = 0;
  logic [31:0] m_ctrl, m_pre, m_cnt;
  logic m_pend, m_irq;
  int m_ph;
  always #5 clk = ~clk;
  timer_counter #(.BASE(BASE)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .byteen(byteen),
    .wdata(wdata), .rdata(rdata), .irq(irq)
  );
  task automatic model_step();
    logic [31:0] n_ctrl, n_pre, n_cnt;
    logic n_pend, hit;
    int n_ph;
    if (reset) begin
      m_ctrl = 0; m_pre = 0; m_cnt = 0; m_pend = 0; m_irq = 0; m_ph = P_IDLE;
      return;
    end
    n_ctrl = m_ctrl; n_pre = m_pre; n_cnt = m_cnt; n_pend = m_pend; n_ph = m_ph;
    if (m_ph == P_IDLE && m_ctrl[0]) n_ph = P_LOAD;
    else if (m_ph == P_LOAD) begin n_cnt = m_pre; n_ph = P_RUN; end
    else if (m_ph == P_RUN) begin
      if (!m_ctrl[0]) n_ph = P_IDLE;
      else if (m_cnt >= 2) n_cnt = m_cnt - 1;
      else begin n_cnt = 0; n_pend = 1; n_ph = P_FIRE; end
    end else if (m_ph == P_FIRE) begin
      n_ph = P_IDLE;
      if (m_ctrl[2:1] == 2'b01) n_pend = 0; else n_ctrl[0] = 0;
    end
    hit = we && addr[31:4] == BASE[31:4];
    if (hit && addr[3:2] <= 2'd1) n_pend = 0;
    if (hit && addr[3:2] == 2'd0 && byteen[0]) n_ctrl = {28'd0, wdata[3:0]};
    if (hit && addr[3:2] == 2'd1)
      for (int b = 0; b < 4; b++) if (byteen[b]) n_pre[8*b +: 8] = wdata[8*b +: 8];
    m_ctrl = n_ctrl; m_pre = n_pre; m_cnt = n_cnt; m_pend = n_pend; m_ph = n_ph;
    m_irq = n_pend & n_ctrl[3];
  endtask
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; byteen = be; wdata = d; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    we = 1'b0; addr = a;
    #1;
    v = rdata;
  endtask
  task automatic do_reset();
    reset = 1'b1; we = 1'b0;
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; we = 1'b1; addr = BASE; byteen = 4'hF; wdata = 32'hDEAD_BEEF;
    cyc();
    wdata = 32'h0000_000F; addr = BASE + 4;
    cyc();
    reset = 1'b0; we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 4 * i, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL reset_reg%0d got=%h exp=0", i, v); end
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
  endtask
  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd5);
    wr(BASE, 4'hF, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k >= 2 && k <= 7) begin
        rd(BASE + 8, v);
        checks++;
        if (v !== 32'(7 - k)) begin failures++; $display("FAIL oneshot_count E%0d got=%0d exp=%0d", k, v, 7 - k); end
      end
      checks++;
      if (irq !== (k >= 7)) begin failures++; $display("FAIL oneshot_irq E%0d got=%b exp=%b", k, irq, k >= 7); end
    end
    rd(BASE, v);
    checks++;
    if (v !== 32'h8) begin failures++; $display("FAIL oneshot_ctrl got=%h exp=8", v); end
    repeat (3) cyc();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_hold got=%b exp=1", irq); end
    wr(BASE, 4'h1, 32'h8);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_ack got=%b exp=0", irq); end
  endtask
  task automatic test_autoreload();
    logic [31:0] v;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd3);
    wr(BASE, 4'hF, 32'hB);
    for (int k = 1; k <= 25; k++) begin
      cyc();
      checks++;
      if (irq !== (k >= 5 && (k - 5) % 6 == 0)) begin
        failures++; $display("FAIL autoreload_irq E%0d got=%b exp=%b", k, irq, k >= 5 && (k - 5) % 6 == 0);
      end
    end
    rd(BASE, v);
    checks++;
    if (v !== 32'hB) begin failures++; $display("FAIL autoreload_ctrl got=%h exp=b", v); end
  endtask
  task automatic test_mask_byteen();
    logic [31:0] v;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd2);
    wr(BASE, 4'hF, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq E%0d got=%b exp=0", k, irq); end
    end
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL mask_count got=%0d exp=0", v); end
    wr(BASE, 4'b0001, 32'hFFFF_FF08);
    rd(BASE, v);
    checks++;
    if (v !== 32'h8) begin failures++; $display("FAIL byteen_ctrl got=%h exp=8", v); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL mask_ack_irq got=%b exp=0", irq); end
    wr(BASE + 4, 4'hF, 32'h1234_5678);
    wr(BASE + 4, 4'b0010, 32'h0000_AB00);
    rd(BASE + 4, v);
    checks++;
    if (v !== 32'h1234_AB78) begin failures++; $display("FAIL byteen_preset got=%h exp=1234ab78", v); end
  endtask
  task automatic test_pause_edges();
    logic [31:0] v;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd20);
    wr(BASE, 4'hF, 32'h1);
    repeat (15) cyc();
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd7) begin failures++; $display("FAIL pause_pre got=%0d exp=7", v); end
    wr(BASE, 4'hF, 32'h0);
    repeat (3) cyc();
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd6) begin failures++; $display("FAIL pause_frozen got=%0d exp=6", v); end
    wr(BASE, 4'hF, 32'h1);
    cyc();
    cyc();
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd20) begin failures++; $display("FAIL pause_reload got=%0d exp=20", v); end
    do_reset();
    wr(BASE, 4'hF, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if (irq !== (k == 3)) begin failures++; $display("FAIL preset0_irq E%0d got=%b exp=%b", k, irq, k == 3); end
    end
    do_reset();
    wr(BASE + 4, 4'hF, 32'h55);
    wr(BASE, 4'hF, 32'h8);
    wr(BASE + 8, 4'hF, 32'hFFFF_FFFF);
    wr(BASE + 12, 4'hF, 32'hFFFF_FFFF);
    wr(BASE + 32'h10, 4'hF, 32'hF);
    wr(BASE + 32'h14, 4'hF, 32'h77);
    rd(BASE, v);
    checks++;
    if (v !== 32'h8) begin failures++; $display("FAIL stray_ctrl got=%h exp=8", v); end
    rd(BASE + 4, v);
    checks++;
    if (v !== 32'h55) begin failures++; $display("FAIL stray_preset got=%h exp=55", v); end
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL stray_count got=%h exp=0", v); end
    rd(BASE + 12, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL stray_idx3 got=%h exp=0", v); end
    rd(BASE + 32'h10, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL stray_unsel got=%h exp=0", v); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    wr(BASE + 4, 4'hF, 32'd6);
    wr(BASE, 4'hF, 32'h9);
    repeat (4) cyc();
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd4) begin failures++; $display("FAIL midreset_pre got=%0d exp=4", v); end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 4 * i, v);
      checks++;
      if (v !== 32'd0) begin failures++; $display("FAIL midreset_reg%0d got=%h exp=0", i, v); end
    end
    wr(BASE + 4, 4'hF, 32'd1);
    wr(BASE, 4'hF, 32'h9);
    repeat (4) cyc();
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL midreset_irq_pre got=%b exp=1", irq); end
    do_reset();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", irq); end
    cyc();
    rd(BASE + 8, v);
    checks++;
    if (v !== 32'd0) begin failures++; $display("FAIL midreset_idle got=%h exp=0", v); end
  endtask
  task automatic test_random();
    logic [31:0] v, e;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 99) < 15);
      byteen = 4'($urandom_range(1, 15));
      case ($urandom_range(0, 6))
        0, 1: addr = BASE + 32'($urandom_range(0, 3));
        2: addr = BASE + 4 + 32'($urandom_range(0, 3));
        3: addr = BASE + 8 + 32'($urandom_range(0, 3));
        4: addr = BASE + 12;
        5: addr = BASE + 32'h10 + 32'($urandom_range(0, 15));
        default: addr = $urandom;
      endcase
      wdata = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
      if (addr[3:2] == 2'd1 && byteen[0]) wdata[7:0] = 8'($urandom_range(0, 6));
      cyc();
      reset = 1'b0;
      checks++;
      if (irq !== m_irq) begin failures++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_irq); end
      for (int i = 0; i < 4; i++) begin
        rd(BASE + 4 * i, v);
        e = (i == 0) ? m_ctrl : (i == 1) ? m_pre : (i == 2) ? m_cnt : 32'd0;
        checks++;
        if (v !== e) begin failures++; $display("FAIL rand_reg%0d n=%0d got=%h exp=%h", i, n, v, e); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask_byteen();
    test_pause_edges();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
